// File: rtl/pool_pkg.sv
// Shared types and sizing helpers for the pooling / unpooling stream stages.
// Used by the 2x2 upsampler and its line buffer.
package pool_pkg;

    typedef enum logic {
        FILL,
        REPLAY
    } upsample_state_t;

    localparam int DEF_DATA_WIDTH = 24;

    function automatic int cnt_width(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/upsample_line_buf.sv
// Single-port pixel line buffer: registered write, combinational read.
// Holds one pooled row so the upsampler can replay it as the odd output row.
module upsample_line_buf
    import pool_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = 9,
    parameter int AW         = cnt_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (we && addr == AW'(i)) begin
                mem[i] <= wdata;
            end
        end
    end

    always_comb begin
        rdata = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (addr == AW'(i)) begin
                rdata = mem[i];
            end
        end
    end

endmodule

// File: rtl/upsample2x2_stream.sv
// Streaming 2x2 unpool: nearest-neighbour replication, or sparse zero fill
// when UPSAMPLE_ZERO_FILL_EN is defined.
module upsample2x2_stream
    import pool_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int IN_WIDTH   = 9,
    parameter int IN_HEIGHT  = 9
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_pixel,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_pixel,
    output logic                  out_last
);

    localparam int CW = cnt_width(IN_WIDTH);
    localparam int RW = cnt_width(IN_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(IN_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IN_HEIGHT - 1);

    upsample_state_t       state;
    logic [CW-1:0]         col;
    logic [RW-1:0]         row;
    logic                  dup;
    logic                  slot_free;
    logic                  in_fire;
    logic                  col_end;
    logic                  row_end;
    logic [DATA_WIDTH-1:0] dup_pix;
    logic [DATA_WIDTH-1:0] replay_pix;

    assign slot_free = !out_valid || out_ready;
    assign in_ready  = slot_free && (state == FILL) && !dup;
    assign in_fire   = in_valid && in_ready;
    assign col_end   = (col == COL_LAST);
    assign row_end   = (row == ROW_LAST);

`ifdef UPSAMPLE_ZERO_FILL_EN
    assign dup_pix    = '0;
    assign replay_pix = '0;
`else
    logic [DATA_WIDTH-1:0] rd_data;

    upsample_line_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (IN_WIDTH),
        .AW         (CW)
    ) u_line_buf (
        .clk   (clk),
        .we    (in_fire),
        .addr  (col),
        .wdata (in_pixel),
        .rdata (rd_data)
    );

    // The second FILL copy simply repeats the registered pixel.
    assign dup_pix    = out_pixel;
    assign replay_pix = rd_data;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= FILL;
            col       <= '0;
            row       <= '0;
            dup       <= 1'b0;
            out_valid <= 1'b0;
            out_pixel <= '0;
            out_last  <= 1'b0;
        end else if (slot_free) begin
            out_last <= 1'b0;
            unique case (state)
                FILL: begin
                    if (dup) begin
                        out_pixel <= dup_pix;
                        out_valid <= 1'b1;
                        dup       <= 1'b0;
                        if (col_end) begin
                            col   <= '0;
                            state <= REPLAY;
                        end else begin
                            col <= col + 1'b1;
                        end
                    end else if (in_fire) begin
                        out_pixel <= in_pixel;
                        out_valid <= 1'b1;
                        dup       <= 1'b1;
                    end else begin
                        out_valid <= 1'b0;
                    end
                end
                REPLAY: begin
                    out_pixel <= replay_pix;
                    out_valid <= 1'b1;
                    dup       <= !dup;
                    if (dup) begin
                        out_last <= col_end && row_end;
                        if (col_end) begin
                            col   <= '0;
                            state <= FILL;
                            row   <= row_end ? '0 : row + 1'b1;
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= FILL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_upsample2x2_stream.sv
// Scoreboard bench for upsample2x2_stream: 9x9, 2x2 and 1x1 instances
// driven side by side, checked against a frame-level reference model.
module tb_upsample2x2_stream;

    localparam int DW = 24;
    localparam int N  = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          in_valid  [N];
    logic          in_ready  [N];
    logic [DW-1:0] in_pixel  [N];
    logic          out_valid [N];
    logic          out_ready [N];
    logic [DW-1:0] out_pixel [N];
    logic          out_last  [N];

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int D = (g == 0) ? 9 : (g == 1) ? 2 : 1;
        upsample2x2_stream #(
            .DATA_WIDTH (DW),
            .IN_WIDTH   (D),
            .IN_HEIGHT  (D)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_pixel  (in_pixel[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out_pixel (out_pixel[g]),
            .out_last  (out_last[g])
        );
    end

    logic [DW:0]   exp_q [N][$];
    int            rmode [N];
    bit            tog [N];
    bit            stall_prev [N];
    logic [DW-1:0] prev_pix [N];
    logic          prev_last [N];
    int            n_pass = 0;
    int            n_chk = 0;
    bit            gap_en = 0;
    bit            seen_first = 0;
    int            gaps = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t",
                      name, act, exp, $time);
    endtask

    // Reference: output (y,x) comes from pooled pixel (y/2, x/2).
    task automatic push_frame(input int d, input int w, input int h,
                              input logic [DW-1:0] px[$]);
        logic [DW-1:0] v;
        for (int y = 0; y < 2 * h; y++) begin
            for (int x = 0; x < 2 * w; x++) begin
                v = px[(y / 2) * w + x / 2];
`ifdef UPSAMPLE_ZERO_FILL_EN
                if ((y % 2) != 0 || (x % 2) != 0) v = '0;
`endif
                exp_q[d].push_back({(y == 2 * h - 1 && x == 2 * w - 1), v});
            end
        end
    endtask

    // Entered and left on a falling edge.
    task automatic send_frame(input int d, input int w, input int h,
                              input int nsend, input bit gaps_on,
                              input bit rnd, input int base);
        logic [DW-1:0] px[$];
        bit hs;
        for (int k = 0; k < w * h; k++)
            px.push_back(rnd ? DW'($urandom) : DW'(base + k));
        push_frame(d, w, h, px);
        for (int k = 0; k < nsend; k++) begin
            if (gaps_on && $urandom_range(0, 3) == 0) begin
                in_valid[d] = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
            in_valid[d] = 1'b1;
            in_pixel[d] = px[k];
            hs = 1'b0;
            for (int t = 0; t < 64 && !hs; t++) begin
                #2;
                hs = in_ready[d];
                @(negedge clk);
            end
            if (!hs) begin
                chk($sformatf("d%0d_accept_timeout", d), 32'(hs), 1);
                break;
            end
        end
        in_valid[d] = 1'b0;
    endtask

    task automatic drain(input int d);
        for (int t = 0; t < 4000 && exp_q[d].size() != 0; t++)
            @(negedge clk);
        if (exp_q[d].size() != 0) begin
            chk($sformatf("d%0d_drain_timeout", d), exp_q[d].size(), 0);
            exp_q[d].delete();
        end
    endtask

    always @(negedge clk) begin
        logic [DW:0] e;
        for (int i = 0; i < N; i++) begin
            case (rmode[i])
                0: out_ready[i] = 1'b1;
                1: begin
                    tog[i] = !tog[i];
                    out_ready[i] = tog[i] && ($urandom_range(0, 5) != 0);
                end
                default: out_ready[i] = ($urandom_range(0, 3) != 0);
            endcase
        end
        #1;
        for (int i = 0; i < N; i++) begin
            if (!rst_n) begin
                stall_prev[i] = 1'b0;
            end else begin
                if (stall_prev[i]) begin
                    chk($sformatf("d%0d_hold_valid", i), 32'(out_valid[i]), 1);
                    chk($sformatf("d%0d_hold_pixel", i), 32'(out_pixel[i]),
                        32'(prev_pix[i]));
                    chk($sformatf("d%0d_hold_last", i), 32'(out_last[i]),
                        32'(prev_last[i]));
                end
                if (out_valid[i] && !out_ready[i])
                    chk($sformatf("d%0d_stall_in_ready", i), 32'(in_ready[i]), 0);
                if (out_valid[i] && out_ready[i]) begin
                    if (exp_q[i].size() == 0) begin
                        chk($sformatf("d%0d_unexpected_output", i),
                            32'(out_valid[i]), 0);
                    end else begin
                        e = exp_q[i].pop_front();
                        chk($sformatf("d%0d_pixel", i), 32'(out_pixel[i]),
                            32'(e[DW-1:0]));
                        chk($sformatf("d%0d_last", i), 32'(out_last[i]),
                            32'(e[DW]));
                    end
                end
                stall_prev[i] = out_valid[i] && !out_ready[i];
                prev_pix[i]   = out_pixel[i];
                prev_last[i]  = out_last[i];
            end
        end
        if (gap_en && rst_n) begin
            if (out_valid[0]) seen_first = 1'b1;
            else if (seen_first && exp_q[0].size() != 0) gaps++;
        end
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            in_valid[i]   = 1'b0;
            in_pixel[i]   = '0;
            out_ready[i]  = 1'b1;
            rmode[i]      = 0;
            tog[i]        = 1'b0;
            stall_prev[i] = 1'b0;
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            chk($sformatf("d%0d_rst_valid", i), 32'(out_valid[i]), 0);
            chk($sformatf("d%0d_rst_pixel", i), 32'(out_pixel[i]), 0);
            chk($sformatf("d%0d_rst_last", i), 32'(out_last[i]), 0);
            chk($sformatf("d%0d_rst_in_ready", i), 32'(in_ready[i]), 1);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // 2x2 frame {1,2,3,4}: free-running, then toggling / stalled sink.
        send_frame(1, 2, 2, 4, 0, 0, 1);
        drain(1);
        rmode[1] = 1;
        send_frame(1, 2, 2, 4, 0, 0, 1);
        drain(1);
        rmode[1] = 0;

        // Two 9x9 frames 0..80 back to back; the output must never bubble.
        gap_en = 1'b1;
        send_frame(0, 9, 9, 81, 0, 0, 0);
        send_frame(0, 9, 9, 81, 0, 0, 0);
        drain(0);
        gap_en = 1'b0;
        chk("d0_frame_gap_cycles", gaps, 0);

        // Random pixels, random input gaps, random back-pressure.
        rmode[0] = 2;
        repeat (2) send_frame(0, 9, 9, 81, 1, 1, 0);
        drain(0);

        // Reset mid-frame, then a fresh frame with no stale data.
        rmode[0] = 0;
        send_frame(0, 9, 9, 5, 0, 1, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        for (int i = 0; i < N; i++) exp_q[i].delete();
        rst_n = 1'b1;
        #1;
        chk("d0_valid_after_reset", 32'(out_valid[0]), 0);
        @(negedge clk);
        rmode[0] = 2;
        send_frame(0, 9, 9, 81, 1, 1, 0);
        drain(0);

        // 1x1 frame: four outputs, first one the cycle after acceptance.
        send_frame(2, 1, 1, 1, 0, 0, 'hABCDEF);
        #1;
        chk("d2_first_output_latency", 32'(out_valid[2]), 1);
        @(negedge clk);
        drain(2);
        repeat (4) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/upsample2x2_stream.md
Name: upsample2x2_stream

Overview:
- Streaming 2x2 nearest-neighbour upsampler (unpool). It is the decode-side counterpart of the 2x2 max-pool stage.
- Consumes a raster stream of pooled pixels, IN_WIDTH x IN_HEIGHT.
- Emits a raster stream of 2*IN_WIDTH x 2*IN_HEIGHT pixels.
- Sits after the pooled feature path, feeding the reconstruction/decoder convolution stages.
- Uses valid/ready on both sides, because output volume is 4x input.

Parameters:
- DATA_WIDTH, 24, pixel width in bits.
- IN_WIDTH, 9, pooled row length in pixels; must be >= 1.
- IN_HEIGHT, 9, pooled rows per frame; must be >= 1.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  in_pixel valid.
- in_ready  output  1  block accepts in_pixel this cycle.
- in_pixel  input  DATA_WIDTH  pooled pixel, raster order.
- out_valid  output  1  out_pixel valid.
- out_ready  input  1  downstream accepts out_pixel.
- out_pixel  output  DATA_WIDTH  upsampled pixel, raster order.
- out_last  output  1  qualifies the final pixel of the output frame.

Behaviour:
- Reset (clk edge with rst_n=0):
  - out_valid=0, out_pixel=0, out_last=0.
  - state=FILL, col=0, row=0, dup=0.
  - Line buffer contents are not reset; every entry is written in FILL before REPLAY reads it.
  - Reset mid-frame discards the partial frame; the next accepted input is treated as pixel (0,0).
- slot_free = !out_valid || out_ready. All advances require slot_free.
- out_pixel/out_valid/out_last are registered and stable while out_valid && !out_ready.
- State FILL produces output row 2r:
  - in_ready = slot_free && dup==0.
  - On input handshake: out_pixel<=in_pixel, linebuf[col]<=in_pixel, out_valid<=1, dup<=1.
  - If dup==1 && slot_free: re-emit the same pixel, dup<=0, col++.
  - When col==IN_WIDTH-1 on that step: col<=0, state<=REPLAY.
  - If dup==0, slot_free and no input: out_valid<=0 (bubble).
- State REPLAY produces output row 2r+1:
  - in_ready=0.
  - On slot_free: out_pixel<=linebuf[col], out_valid<=1, dup toggles; col++ after the second copy.
  - After the second copy of col==IN_WIDTH-1: col<=0, dup<=0, state<=FILL, row++.
  - If row==IN_HEIGHT-1 at that point: row<=0 (frame wrap).
- out_last=1 only with the second copy of the last column, REPLAY state, row==IN_HEIGHT-1; 0 otherwise.
- Latency: first output is registered the cycle after the first input handshake.
- Throughput:
  - With out_ready=1, one output per cycle in REPLAY.
  - FILL accepts at most one input per two cycles; no input during REPLAY.
- Back-to-back frames need no idle cycle; the next frame's first input is accepted in the first FILL cycle after wrap.
- Edge sizes:
  - IN_WIDTH=1: FILL emits 2 pixels, then REPLAY emits 2.
  - IN_WIDTH=IN_HEIGHT=1: 4 outputs total, out_last on the 4th.
- Counter widths: col is $clog2(IN_WIDTH)+1 bits; row is $clog2(IN_HEIGHT)+1 bits. No overflow is possible.

Optional Feature:
- Macro: UPSAMPLE_ZERO_FILL_EN.
- Defined: sparse unpool.
  - Each input pixel appears only at the top-left of its 2x2 block.
  - FILL emits pixel then 0.
  - REPLAY emits 0,0 per column.
  - Line buffer and its writes are compiled out. Handshake, timing and out_last are unchanged.
- Undefined: nearest-neighbour replication as described above.

Decomposition:
- Shared package pool_pkg:
  - typedef enum logic {FILL, REPLAY} upsample_state_t.
  - Default DATA_WIDTH constant.
  - Helper localparam function for counter width.
- Sub-module upsample_line_buf: single-port IN_WIDTH x DATA_WIDTH register array with write-enable and combinational read. Not instantiated under UPSAMPLE_ZERO_FILL_EN.

Test Plan:
- 2x2 input {1,2,3,4}, out_ready=1, in_valid=1 continuously:
  - Output is 1,1,2,2, 1,1,2,2, 3,3,4,4, 3,3,4,4.
  - out_last only on the 16th output.
  - in_ready low throughout REPLAY.
- Same frame with out_ready toggling 1,0,1,0 and a random stall:
  - Identical 16-value sequence.
  - out_pixel is held stable on every out_valid && !out_ready cycle.
  - No input is accepted while the slot is stalled.
- Default 9x9 frame with values 0..80, two frames back-to-back:
  - 324 outputs per frame.
  - Output (y,x) = in[y/2][x/2].
  - out_last exactly twice.
  - Second frame starts with no idle cycle.
- rst_n low for one cycle after 5 inputs of a 9x9 frame, then a fresh 9x9 frame:
  - out_valid=0 the cycle after reset.
  - Fresh frame output matches reference with no stale pixels.
- IN_WIDTH=IN_HEIGHT=1, input 0xABCDEF: outputs 0xABCDEF x4, out_last on the 4th.
- With UPSAMPLE_ZERO_FILL_EN, 2x2 input {1,2,3,4}: outputs 1,0,2,0, 0,0,0,0, 3,0,4,0, 0,0,0,0, with out_last on the 16th.
